// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: FSM state encoding and branch condition codes.
`timescale 1ns/1ps
package alu_result_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_TRAP  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_BLTZ = 2'b11
  } br_type_e;

endpackage

// File: rtl/alu_result_stage_branch.sv
// Combinational branch condition evaluation from the ALU flags.
`timescale 1ns/1ps
module branch_cond_eval
  import alu_result_stage_pkg::*;
(
  input  logic [1:0] br_type,
  input  logic       zero,
  input  logic       negative,
  output logic       taken
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    taken = 1'b0;
    case (br_type_e'(br_type))
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      BR_BLTZ: taken = negative;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// One-entry ALU result holding stage with branch decision and overflow trap capture.
`timescale 1ns/1ps
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DEST_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              ovf_check,
  input  logic [1:0]        br_type,
  input  logic [DEST_W-1:0] dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_zero,
  output logic              out_negative,
  output logic              branch_taken,
  output logic              trap,
  input  logic              trap_ack,
  output logic [31:0]       trap_value,
  output logic [CNT_W-1:0]  trap_count
);

  state_e              state_q, state_d;
  logic [31:0]         out_result_q, out_result_d;
  logic [DEST_W-1:0]   out_dest_q, out_dest_d;
  logic                out_zero_q, out_zero_d;
  logic                out_negative_q, out_negative_d;
  logic                branch_taken_q, branch_taken_d;
  logic [31:0]         trap_value_q, trap_value_d;
  logic [CNT_W-1:0]    trap_count_q, trap_count_d;
  logic                taken_c;
  logic                trap_hit;
  logic                capture;

  branch_cond_eval u_branch (
    .br_type  (br_type),
    .zero     (alu_zero),
    .negative (alu_negative),
    .taken    (taken_c)
  );

  assign trap_hit = ovf_check & alu_overflow;
  assign capture  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_valid) state_d = trap_hit ? ST_TRAP : ST_FULL;
      ST_FULL: begin
        if (out_ready) state_d = !in_valid ? ST_EMPTY : (trap_hit ? ST_TRAP : ST_FULL);
      end
      ST_TRAP:  if (trap_ack) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // in_ready is the only combinational output; FULL lets a drain and refill share a cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    trap      = 1'b0;
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_FULL: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      ST_TRAP:  trap = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  always_comb begin
    out_result_d   = out_result_q;
    out_dest_d     = out_dest_q;
    out_zero_d     = out_zero_q;
    out_negative_d = out_negative_q;
    branch_taken_d = branch_taken_q;
    trap_value_d   = trap_value_q;
    trap_count_d   = trap_count_q;
    if (capture && !trap_hit) begin
      out_result_d   = alu_result;
      out_dest_d     = dest;
      out_zero_d     = alu_zero;
      out_negative_d = alu_negative;
      branch_taken_d = taken_c;
    end
    if (capture && trap_hit) begin
      trap_value_d = alu_result;
      if (trap_count_q != '1) trap_count_d = trap_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_result_q   <= '0;
      out_dest_q     <= '0;
      out_zero_q     <= 1'b0;
      out_negative_q <= 1'b0;
      branch_taken_q <= 1'b0;
      trap_value_q   <= '0;
      trap_count_q   <= '0;
    end else begin
      out_result_q   <= out_result_d;
      out_dest_q     <= out_dest_d;
      out_zero_q     <= out_zero_d;
      out_negative_q <= out_negative_d;
      branch_taken_q <= branch_taken_d;
      trap_value_q   <= trap_value_d;
      trap_count_q   <= trap_count_d;
    end
  end

  assign out_result   = out_result_q;
  assign out_dest     = out_dest_q;
  assign out_zero     = out_zero_q;
  assign out_negative = out_negative_q;
  assign branch_taken = branch_taken_q;
  assign trap_value   = trap_value_q;
  assign trap_count   = trap_count_q;

endmodule
